// File: rtl/seq_display_if.sv
// Bus bundle between the status source and the seq_display driver.
// The master drives the values and the load request; the slave returns the display state.
interface seq_display_if #(
   parameter int IN_WIDTH = 6,
   parameter int CHANNELS = 2,
   parameter int DIGITS   = 2
);
   logic [CHANNELS*IN_WIDTH-1:0]  in;
   logic                          load;
   logic                          busy;
   logic                          valid;
   logic [CHANNELS-1:0]           overflow;
   logic [CHANNELS*DIGITS*7-1:0]  hex;

   modport master (output in, load, input busy, valid, overflow, hex);
   modport slave  (input in, load, output busy, valid, overflow, hex);
endinterface

// File: rtl/seq_display.sv
// Multi-channel seven-segment driver: snapshots all channels on load, converts them
// serially with a shift-and-add-3 engine, then updates every digit at once.
module seq_display #(
   parameter int IN_WIDTH      = 6,
   parameter int CHANNELS      = 2,
   parameter int DIGITS        = 2,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic           clk,
   input logic           rst,
   seq_display_if.slave  bus
);
   localparam int N  = CHANNELS * IN_WIDTH;
   localparam int K0 = (IN_WIDTH + 2) / 3;
   localparam int K  = (DIGITS > K0) ? DIGITS : K0;
   localparam int BW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HW = CHANNELS * DIGITS * 7;

   typedef enum logic [0:0] {IDLE = 1'b0, CONVERT = 1'b1} state_t;

   state_t                        state_r, state_next_s;
   logic [N-1:0]                  hold_r, order_s;
   logic [4*K-1:0]                bcd_r, adj_s, bcd_next_s;
   logic [BW-1:0]                 bit_r;
   logic [CW-1:0]                 ch_r;
   logic [CHANNELS-1:0][4*K-1:0]  stage_r, stage_s;
   logic [HW-1:0]                 hex_r, hex_s;
   logic [CHANNELS-1:0]           ovf_r, ovf_s;
   logic                          busy_r, valid_r;
   logic                          start_s, step_s, last_bit_s, last_ch_s, chan_done_s, finish_s;

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      logic [6:0] code;
      case (digit)
         4'd0:    code = 7'h40;
         4'd1:    code = 7'h79;
         4'd2:    code = 7'h24;
         4'd3:    code = 7'h30;
         4'd4:    code = 7'h19;
         4'd5:    code = 7'h12;
         4'd6:    code = 7'h02;
         4'd7:    code = 7'h78;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h10;
         default: code = 7'h3F;
      endcase
      return code;
   endfunction

   function automatic logic [4*K-1:0] add3(input logic [4*K-1:0] v);
      logic [4*K-1:0] r;
      r = v;
      for (int k = 0; k < K; k++) begin
         if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
         else                     r[4*k +: 4] = v[4*k +: 4];
      end
      return r;
   endfunction

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_next_s;
   end

   // next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    if (bus.load) state_next_s = CONVERT; else state_next_s = IDLE;
         CONVERT: if (finish_s) state_next_s = IDLE;    else state_next_s = CONVERT;
         default: state_next_s = IDLE;
      endcase
   end

   // control strobes decoded from state and counters
   always_comb begin
      start_s = 1'b0;
      step_s  = 1'b0;
      case (state_r)
         IDLE:    start_s = bus.load;
         CONVERT: step_s  = 1'b1;
         default: step_s  = 1'b0;
      endcase
      last_bit_s  = (bit_r == BW'(IN_WIDTH - 1));
      last_ch_s   = (ch_r == CW'(CHANNELS - 1));
      chan_done_s = step_s & last_bit_s;
      finish_s    = chan_done_s & last_ch_s;
   end

   // holding order puts channel 0 MSB at the top so conversion just shifts left
   always_comb begin
      order_s = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         order_s[(CHANNELS-1-c)*IN_WIDTH +: IN_WIDTH] = bus.in[c*IN_WIDTH +: IN_WIDTH];
      end
      adj_s      = add3(bcd_r);
      bcd_next_s = {adj_s[4*K-2:0], hold_r[N-1]};
   end

   // display image built from staging with the channel just finishing folded in
   always_comb begin
      logic lead;
      logic [3:0] nib;
      stage_s       = stage_r;
      stage_s[ch_r] = bcd_next_s;
      hex_s         = '1;
      ovf_s         = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int k = DIGITS; k < K; k++) ovf_s[c] = ovf_s[c] | (|stage_s[c][4*k +: 4]);
         lead = 1'b1;
         for (int d = DIGITS - 1; d >= 0; d--) begin
            nib  = stage_s[c][4*d +: 4];
            lead = lead & (nib == 4'd0);
            if (ovf_s[c])                                  hex_s[(c*DIGITS+d)*7 +: 7] = 7'h3F;
            else if (BLANK_LEADING && (d != 0) && lead)    hex_s[(c*DIGITS+d)*7 +: 7] = 7'h7F;
            else                                           hex_s[(c*DIGITS+d)*7 +: 7] = seg7(nib);
         end
      end
   end

   // datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_r  <= '0;
         bcd_r   <= '0;
         bit_r   <= '0;
         ch_r    <= '0;
         stage_r <= '0;
         hex_r   <= '1;
         ovf_r   <= '0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= finish_s;
         if (start_s) begin
            hold_r <= order_s;
            bcd_r  <= '0;
            bit_r  <= '0;
            ch_r   <= '0;
            busy_r <= 1'b1;
         end else if (step_s) begin
            hold_r <= hold_r << 1'b1;
            if (chan_done_s) begin
               stage_r[ch_r] <= bcd_next_s;
               bcd_r         <= '0;
               bit_r         <= '0;
               ch_r          <= ch_r + 1'b1;
            end else begin
               bcd_r <= bcd_next_s;
               bit_r <= bit_r + 1'b1;
            end
            if (finish_s) begin
               hex_r  <= hex_s;
               ovf_r  <= ovf_s;
               busy_r <= 1'b0;
            end
         end
      end
   end

   assign bus.busy     = busy_r;
   assign bus.valid    = valid_r;
   assign bus.overflow = ovf_r;
   assign bus.hex      = hex_r;
endmodule

// File: tb/tb_seq_display.sv
// Self-checking bench for seq_display: three parameter sets driven by directed
// and random steps, compared against a decimal-arithmetic display model.
module tb_seq_display;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   seq_display_if #(.IN_WIDTH(6), .CHANNELS(2), .DIGITS(2)) i0 ();
   seq_display_if #(.IN_WIDTH(6), .CHANNELS(2), .DIGITS(2)) i1 ();
   seq_display_if #(.IN_WIDTH(6), .CHANNELS(1), .DIGITS(1)) i2 ();

   assign i1.in   = i0.in;
   assign i1.load = i0.load;

   seq_display #(.IN_WIDTH(6), .CHANNELS(2), .DIGITS(2), .BLANK_LEADING(1'b1))
      u0 (.clk(clk), .rst(rst), .bus(i0));
   seq_display #(.IN_WIDTH(6), .CHANNELS(2), .DIGITS(2), .BLANK_LEADING(1'b0))
      u1 (.clk(clk), .rst(rst), .bus(i1));
   seq_display #(.IN_WIDTH(6), .CHANNELS(1), .DIGITS(1), .BLANK_LEADING(1'b1))
      u2 (.clk(clk), .rst(rst), .bus(i2));

   always #5 clk = ~clk;

   // decimal digit d of v as shown on a display with 'digits' positions
   function automatic logic [6:0] exp_digit(int v, int d, int digits, bit bl);
      if (v >= 10 ** digits)             return 7'h3F;
      if (bl && d > 0 && v < 10 ** d)    return 7'h7F;
      return seg_tab[(v / (10 ** d)) % 10];
   endfunction

   function automatic logic [27:0] exp_hex0(int v0, int v1, bit bl);
      logic [27:0] r;
      for (int d = 0; d < 2; d++) begin
         r[d*7 +: 7]     = exp_digit(v0, d, 2, bl);
         r[(2+d)*7 +: 7] = exp_digit(v1, d, 2, bl);
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic conv0(input int v0, input int v1);
      int n;
      int nb;
      i0.in   = {6'(v1), 6'(v0)};
      i0.load = 1'b1;
      step();
      i0.load = 1'b0;
      n  = 0;
      nb = 0;
      while (i0.valid !== 1'b1 && n < 40) begin
         if (i0.busy === 1'b1) nb++;
         step();
         n++;
      end
      chk("latency", 64'(n), 64'd12);
      chk("busy_cycles", 64'(nb), 64'd12);
      chk("busy_at_valid", 64'(i0.busy), 64'd0);
      chk("hex_blank", 64'(i0.hex), 64'(exp_hex0(v0, v1, 1'b1)));
      chk("overflow", 64'(i0.overflow), {62'd0, 1'(v1 >= 100), 1'(v0 >= 100)});
      chk("valid_noblank", 64'(i1.valid), 64'd1);
      chk("hex_noblank", 64'(i1.hex), 64'(exp_hex0(v0, v1, 1'b0)));
      step();
      chk("valid_pulse", 64'(i0.valid), 64'd0);
   endtask

   task automatic conv2(input int v);
      int n;
      i2.in   = 6'(v);
      i2.load = 1'b1;
      step();
      i2.load = 1'b0;
      n = 0;
      while (i2.valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("d1_latency", 64'(n), 64'd6);
      chk("d1_hex", 64'(i2.hex), 64'(exp_digit(v, 0, 1, 1'b1)));
      chk("d1_overflow", 64'(i2.overflow), 64'(v >= 10));
      step();
   endtask

   initial begin
      int n;
      int cnt_v;
      int cnt_b;
      bit ev;
      i0.in   = '0;
      i0.load = 1'b0;
      i2.in   = '0;
      i2.load = 1'b0;
      rst     = 1'b1;
      step();
      step();
      rst = 1'b0;

      chk("rst_hex", 64'(i0.hex), 64'h0FFF_FFFF);
      chk("rst_ovf", 64'(i0.overflow), 64'd0);
      chk("rst_valid", 64'(i0.valid), 64'd0);
      chk("rst_busy", 64'(i0.busy), 64'd0);
      chk("rst_hex_d1", 64'(i2.hex), 64'h7F);

      conv0(37, 5);
      chk("plan_37_5", 64'(i0.hex), {36'd0, 7'h7F, 7'h12, 7'h30, 7'h78});
      conv0(0, 63);
      chk("plan_0_63", 64'(i0.hex), {36'd0, 7'h02, 7'h30, 7'h7F, 7'h40});
      chk("plan_0_63_nb", 64'(i1.hex), {36'd0, 7'h02, 7'h30, 7'h40, 7'h40});
      for (int i = 0; i < 16; i++) conv0(int'($urandom_range(63, 0)), int'($urandom_range(63, 0)));

      conv2(9);
      conv2(10);
      conv2(0);
      for (int i = 0; i < 8; i++) conv2(int'($urandom_range(15, 0)));

      // snapshot and load-while-busy
      i0.in   = {6'd5, 6'd37};
      i0.load = 1'b1;
      step();
      i0.load = 1'b0;
      step();
      step();
      i0.in = {6'd5, 6'd12};
      step();
      step();
      i0.load = 1'b1;
      step();
      i0.load = 1'b0;
      n = 0;
      while (i0.valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("snap_latency", 64'(n), 64'd7);
      chk("snap_hex", 64'(i0.hex), 64'(exp_hex0(37, 5, 1'b1)));
      cnt_v = 0;
      cnt_b = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i0.valid === 1'b1) cnt_v++;
         if (i0.busy === 1'b1) cnt_b++;
      end
      chk("no_queued_valid", 64'(cnt_v), 64'd0);
      chk("no_queued_busy", 64'(cnt_b), 64'd0);

      // reset mid-conversion
      i0.in   = {6'd44, 6'd21};
      i0.load = 1'b1;
      step();
      i0.load = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_hex", 64'(i0.hex), 64'h0FFF_FFFF);
      chk("abort_valid", 64'(i0.valid), 64'd0);
      chk("abort_busy", 64'(i0.busy), 64'd0);
      chk("abort_ovf", 64'(i0.overflow), 64'd0);
      cnt_v = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i0.valid === 1'b1) cnt_v++;
      end
      chk("abort_no_valid", 64'(cnt_v), 64'd0);
      conv0(21, 44);

      // reset and load together
      rst     = 1'b1;
      i0.load = 1'b1;
      step();
      rst     = 1'b0;
      i0.load = 1'b0;
      chk("rst_load_busy", 64'(i0.busy), 64'd0);
      cnt_v = 0;
      cnt_b = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i0.valid === 1'b1) cnt_v++;
         if (i0.busy === 1'b1) cnt_b++;
      end
      chk("rst_load_no_valid", 64'(cnt_v), 64'd0);
      chk("rst_load_no_busy", 64'(cnt_b), 64'd0);

      // back-to-back with load held high
      i0.in   = {6'd58, 6'd9};
      i0.load = 1'b1;
      step();
      for (int i = 1; i <= 52; i++) begin
         ev = (i % 13 == 0);
         chk("b2b_valid", 64'(i0.valid), 64'(ev));
         chk("b2b_busy", 64'(i0.busy), 64'(!ev));
         if (ev) chk("b2b_hex", 64'(i0.hex), 64'(exp_hex0(9, 58, 1'b1)));
         step();
      end
      i0.load = 1'b0;
      n = 0;
      while (i0.valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("b2b_drain", 64'(i0.valid), 64'd1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end
endmodule
